// File: rtl/instr_seq_ctrl_if.sv
// rtl/instr_seq_ctrl_if.sv - instruction fetch handshake bundle
//
// Purpose: groups the req/ack instruction-memory handshake of instr_seq_ctrl.
// Ports (signals):
//   imem_req   controller -> memory  fetch request, held until ack
//   imem_addr  controller -> memory  fetch address (ADDR_W)
//   imem_ack   memory -> controller  fetched data valid this cycle
//   imem_data  memory -> controller  fetched instruction (INS_W)
// Modports: master = controller side, slave = memory side.
interface instr_seq_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int INS_W  = 19
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INS_W-1:0]  imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/instr_seq_ctrl.sv
// rtl/instr_seq_ctrl.sv - multi-cycle fetch/decode/execute sequencer for the lab CPU
//
// Purpose: fetches instructions {op[18:16], A[15:8], B[7:0]} over a req/ack
// handshake, presents op/A/B to a combinational ALU, captures its result and
// steps the PC (jump, halt, increment with halt-or-wrap at the last address).
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   run        in   start/restart, honoured in IDLE and HALT only
//   step       in   (INSTR_SEQ_STEP_EN only) leave PAUSE and fetch next
//   imem       if   instruction fetch handshake (master)
//   dir        out  current PC
//   ins        out  latched instruction
//   op/A/B     out  ALU opcode and operands
//   alu_res    in   combinational ALU result
//   resultado  out  last captured ALU result
//   res_valid  out  one-cycle pulse when resultado updates
//   busy       out  high in FETCH/DECODE/EXEC
//   halted     out  high in HALT
// Optional feature macro: INSTR_SEQ_STEP_EN (single-step PAUSE state).
module instr_seq_ctrl #(
    parameter int ADDR_W      = 6,
    parameter int INS_W       = 19,
    parameter int DATA_W      = 8,
    parameter int HALT_AT_END = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
`ifdef INSTR_SEQ_STEP_EN
    input  logic               step,
`endif
    instr_seq_ctrl_if.master   imem,
    output logic [ADDR_W-1:0]  dir,
    output logic [INS_W-1:0]   ins,
    output logic [2:0]         op,
    output logic [DATA_W-1:0]  A,
    output logic [DATA_W-1:0]  B,
    input  logic [DATA_W-1:0]  alu_res,
    output logic [DATA_W-1:0]  resultado,
    output logic               res_valid,
    output logic               busy,
    output logic               halted
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
`ifdef INSTR_SEQ_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    // Where an EXEC that keeps running goes next; single-step parks in PAUSE.
`ifdef INSTR_SEQ_STEP_EN
    localparam state_t S_AFTER_EXEC = S_PAUSE;
`else
    localparam state_t S_AFTER_EXEC = S_FETCH;
`endif

    state_t            state, state_n;
    logic [ADDR_W-1:0] dir_n;
    logic              load_ins;
    logic              capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        dir_n    = dir;
        load_ins = 1'b0;
        capture  = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_n = S_FETCH;
                    dir_n   = '0;
                end
            end
            S_FETCH: begin
                if (imem.imem_ack) begin
                    load_ins = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                case (ins[INS_W-1 -: 3])
                    3'd7: state_n = S_HALT;
                    3'd6: begin
                        dir_n   = ins[ADDR_W-1:0];
                        state_n = S_AFTER_EXEC;
                    end
                    default: begin
                        capture = 1'b1;
                        if (dir == LAST_ADDR && HALT_AT_END != 0) begin
                            state_n = S_HALT;
                        end else begin
                            // Increment wraps to 0 past the last address.
                            dir_n   = dir + ADDR_ONE;
                            state_n = S_AFTER_EXEC;
                        end
                    end
                endcase
            end
            S_HALT: begin
                if (run) begin
                    dir_n   = '0;
                    state_n = S_FETCH;
                end
            end
`ifdef INSTR_SEQ_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    state_n = S_FETCH;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // op/A/B are loaded together with ins on the ack edge, so they are
    // already valid in DECODE and stay put until the next fetch completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir       <= '0;
            ins       <= '0;
            op        <= '0;
            A         <= '0;
            B         <= '0;
            resultado <= '0;
            res_valid <= 1'b0;
        end else begin
            dir       <= dir_n;
            res_valid <= capture;
            if (capture) begin
                resultado <= alu_res;
            end
            if (load_ins) begin
                ins <= imem.imem_data;
                op  <= imem.imem_data[INS_W-1 -: 3];
                A   <= imem.imem_data[2*DATA_W-1 -: DATA_W];
                B   <= imem.imem_data[DATA_W-1:0];
            end
        end
    end

    // Decoded straight from state so reset removes the request immediately.
    assign imem.imem_req  = (state == S_FETCH);
    assign imem.imem_addr = dir;
    assign busy           = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    assign halted         = (state == S_HALT);
endmodule

// File: doc/instr_seq_ctrl.md
Name: instr_seq_ctrl

Overview:
- Multi-cycle control unit for the lab CPU datapath: program counter, 19-bit instruction memory, 3-bit-opcode 8-bit ALU.
- Fetches each instruction through a req/ack handshake, decodes it into op/A/B for the ALU, and captures the ALU result.
- Handles jump and halt opcodes and advances the PC.
- Sits between instruction memory and the ALU, replacing the free-running PC in the CPU top.

Parameters:
- ADDR_W, 6, PC / instruction-address width.
- INS_W, 19, instruction width; fixed format {op[18:16], A[15:8], B[7:0]}.
- DATA_W, 8, operand/result width.
- HALT_AT_END, 1: 1 = halt after executing address 2^ADDR_W-1; 0 = wrap PC to 0.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  start/restart pulse; sampled in IDLE and HALT only
- imem_req  out  1  instruction fetch request
- imem_addr  out  ADDR_W  fetch address; equals dir
- imem_ack  in  1  fetch data valid this cycle
- imem_data  in  INS_W  fetched instruction
- dir  out  ADDR_W  current PC
- ins  out  INS_W  latched current instruction
- op  out  3  ALU opcode, ins[18:16]
- A  out  DATA_W  ALU operand A, ins[15:8]
- B  out  DATA_W  ALU operand B, ins[7:0]
- alu_res  in  DATA_W  combinational ALU result for op/A/B
- resultado  out  DATA_W  last captured ALU result
- res_valid  out  1  one-cycle pulse when resultado updates
- busy  out  1  high in FETCH/DECODE/EXEC
- halted  out  1  high in HALT

Behaviour:
- Reset (reset=0, async): state=IDLE; dir, ins, op, A, B, resultado = 0; imem_req, res_valid, busy, halted = 0.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE: run=1 -> FETCH with dir=0.
- FETCH:
  - imem_req=1 and imem_addr=dir, held stable until ack.
  - imem_ack=1 -> latch ins<=imem_data, drop req next cycle, -> DECODE.
  - No ack -> stay in FETCH; no timeout.
- DECODE: op/A/B driven from ins (registered, stable from this cycle until next DECODE) -> EXEC.
- EXEC, by op:
  - op 0..5 (ALU): resultado<=alu_res; res_valid=1 for this cycle only.
  - op 6 (JMP): dir<=ins[ADDR_W-1:0]; resultado unchanged; no res_valid.
  - op 7 (HALT): -> HALT; dir unchanged.
- EXEC, ALU op, next PC:
  - dir < 2^ADDR_W-1: dir<=dir+1, -> FETCH.
  - dir == 2^ADDR_W-1 and HALT_AT_END=1: -> HALT, dir unchanged.
  - dir == 2^ADDR_W-1 and HALT_AT_END=0: dir<=0, -> FETCH.
- EXEC, JMP: -> FETCH at the new dir. Jump to self is legal and loops forever.
- HALT: halted=1; run=1 -> dir<=0, -> FETCH, halted drops next cycle.
- Latency: ALU instruction with zero-wait ack = 3 cycles (FETCH, DECODE, EXEC); each wait cycle adds 1.
- Ignored inputs:
  - run in FETCH/DECODE/EXEC.
  - imem_ack when imem_req=0.
  - imem_data outside an ack cycle.
- Reset mid-fetch: imem_req drops asynchronously; any in-flight ack after release is ignored.
- Arithmetic: PC increment is modulo 2^ADDR_W. Result is taken unchanged from alu_res; no flags.

Optional Feature:
- Macro: INSTR_SEQ_STEP_EN.
- Defined:
  - Adds input step (1 bit) and a PAUSE state.
  - Every EXEC that would go to FETCH goes to PAUSE instead.
  - PAUSE holds all outputs with busy=0; step=1 -> FETCH.
  - step is ignored outside PAUSE; HALT paths are unaffected.
- Undefined: no step port, no PAUSE state; behaviour exactly as above.

Test Plan:
- Reset release, run pulse, memory acks every request in the same cycle, mem[0]=19'h00503 (ADD 5,3), ALU model returns A+B -> 3 cycles after FETCH entry: resultado=8'h08, res_valid one cycle, dir=1.
- mem[1]=19'h60004 (JMP 4), mem[4]=19'h70000 (HALT) -> dir goes 1->4, resultado holds 8'h08, halted=1 with dir=4, busy=0.
- Memory delays ack 3 cycles on mem[0] -> imem_req high 4 consecutive cycles with imem_addr=0 stable; instruction completes in 6 cycles; stray ack while req=0 has no effect.
- All 64 words = 19'h00101, HALT_AT_END=1 -> 64 res_valid pulses of 8'h02, then halted with dir=63. HALT_AT_END=0 -> dir wraps 63->0 and fetching continues.
- reset asserted during FETCH wait -> imem_req=0 and all outputs 0 immediately. After release, idle until run; fetch restarts at dir=0.
- INSTR_SEQ_STEP_EN defined -> after mem[0] executes, controller stays in PAUSE (busy=0, dir=1) for 10 cycles; one step pulse -> fetches mem[1].
